// File: rtl/yuv_stream_pkg.sv
// Shared types and constants for the YUV422 capture-to-RGB pipeline.
// Phase encoding, default frame geometry and coordinate width.
package yuv_stream_pkg;

    typedef enum logic [1:0] {
        PH_Y0,
        PH_U,
        PH_Y1,
        PH_V
    } phase_t;

    localparam int IMG_WIDTH_DEF  = 320;
    localparam int IMG_HEIGHT_DEF = 466;
    localparam int COORD_W        = 10;

endpackage

// File: rtl/yuyv_to_yuv422p_unpack.sv
// Unpacks a YUYV byte stream into one y/u/v pixel per cycle with coordinates.
// Locks on SOF, resynchronises on misaligned SOF and free-runs between frames.
module yuyv_to_yuv422p_unpack
    import yuv_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_sof,
    output logic               data_valid,
    output logic [7:0]         y_data,
    output logic [7:0]         u_data,
    output logic [7:0]         v_data,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_done,
    output logic               sync_err
);

    localparam logic [COORD_W-1:0] W_L = COORD_W'(IMG_WIDTH);
    localparam logic [COORD_W-1:0] H_L = COORD_W'(IMG_HEIGHT);

    phase_t             phase;
    logic               locked;
    logic [7:0]         y0, u, y1;
    logic [COORD_W-1:0] ix, iy;

    // Pair buffer: the second pixel of a group waits here for one cycle.
    logic               pend;
    logic [7:0]         b_y1;
    logic [COORD_W-1:0] b_x, b_y;

    logic v_accept;
    assign v_accept = in_valid && !in_sof && locked && (phase == PH_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= PH_Y0;
            locked     <= 1'b0;
            y0         <= '0;
            u          <= '0;
            y1         <= '0;
            ix         <= '0;
            iy         <= '0;
            pend       <= 1'b0;
            b_y1       <= '0;
            b_x        <= '0;
            b_y        <= '0;
            data_valid <= 1'b0;
            y_data     <= '0;
            u_data     <= '0;
            v_data     <= '0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (pend) begin
                data_valid <= 1'b1;
                y_data     <= b_y1;
                pixel_x    <= b_x + COORD_W'(1);
                pend       <= 1'b0;
                frame_done <= (b_x == W_L - COORD_W'(2)) &&
                              (b_y == H_L - COORD_W'(1));
            end
            if (in_valid) begin
                if (in_sof) begin
                    if (locked && (phase != PH_Y0 || ix != '0 || iy != '0))
                        sync_err <= 1'b1;
                    locked <= 1'b1;
                    phase  <= PH_U;
                    y0     <= in_data;
                    ix     <= '0;
                    iy     <= '0;
                end else if (locked) begin
                    unique case (phase)
                        PH_Y0: begin
                            y0    <= in_data;
                            phase <= PH_U;
                        end
                        PH_U: begin
                            u     <= in_data;
                            phase <= PH_Y1;
                        end
                        PH_Y1: begin
                            y1    <= in_data;
                            phase <= PH_V;
                        end
                        PH_V: begin
                            phase      <= PH_Y0;
                            data_valid <= 1'b1;
                            y_data     <= y0;
                            u_data     <= u;
                            v_data     <= in_data;
                            pixel_x    <= ix;
                            pixel_y    <= iy;
                            b_y1       <= y1;
                            b_x        <= ix;
                            b_y        <= iy;
                            pend       <= 1'b1;
                            if (ix == W_L - COORD_W'(2)) begin
                                ix <= '0;
                                if (iy == H_L - COORD_W'(1))
                                    iy <= '0;
                                else
                                    iy <= iy + COORD_W'(1);
                            end else begin
                                ix <= ix + COORD_W'(2);
                            end
                        end
                    endcase
                end
            end
        end
    end

    // A new group can never complete while the previous pair is mid-emission.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) v_accept |-> !pend
    );

endmodule

// File: doc/yuyv_to_yuv422p_unpack.md
Name: yuyv_to_yuv422p_unpack

Overview:
- Upstream feeder of the YUV422 planar-to-RGB converter.
- Accepts a packed YUYV byte stream (Y0 U0 Y1 V0 ...) from the capture/DMA side, one byte per accepted cycle.
- Emits one pixel per output cycle as parallel y/u/v with pixel coordinates. Both pixels of a pair carry the same U/V.
- Handles frame lock on a start-of-frame marker, and detects and recovers from mid-group resynchronisation.

Parameters:
- IMG_WIDTH, 320, pixels per line; must be even and at least 2.
- IMG_HEIGHT, 466, lines per frame; at least 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data/in_sof qualify this cycle; no backpressure.
- in_data  in  8  packed YUYV byte.
- in_sof  in  1  marks the first Y byte of a frame; ignored unless in_valid.
- data_valid  out  1  one pixel presented this cycle.
- y_data  out  8  luma of the presented pixel.
- u_data  out  8  Cb shared by the pair.
- v_data  out  8  Cr shared by the pair.
- pixel_x  out  10  column of the presented pixel, 0..IMG_WIDTH-1.
- pixel_y  out  10  row of the presented pixel, 0..IMG_HEIGHT-1.
- frame_done  out  1  single-cycle pulse coincident with the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1).
- sync_err  out  1  single-cycle pulse when a SOF arrives out of alignment.

Behaviour:
- Reset: every output is 0; phase=PH_Y0; locked=0; pair buffer empty; input counters ix=0, iy=0.
- Lock:
  - While locked=0, all bytes are discarded.
  - The first in_valid&&in_sof sets locked=1 and that byte is taken as Y0 of pixel (0,0).
- Phase FSM (advances only on in_valid while locked):
  - PH_Y0 -> PH_U: latch y0.
  - PH_U -> PH_Y1: latch u.
  - PH_Y1 -> PH_V: latch y1.
  - PH_V -> PH_Y0: latch v and complete the group.
- Group completion:
  - On the V byte, {y0, y1, u, v, ix, iy} are copied into the pair buffer and pend is set.
  - ix += 2. When ix reaches IMG_WIDTH, ix wraps to 0 and iy increments. When iy reaches IMG_HEIGHT, iy wraps to 0.
  - Frames free-run; SOF only resynchronises.
- Emission:
  - Cycle after V accepted: data_valid=1, y_data=y0, pixel_x=px.
  - Following cycle: data_valid=1, y_data=y1, pixel_x=px+1.
  - u/v/pixel_y are identical in both cycles. Then pend clears.
  - Latency from V byte to first pixel is 1 cycle; to the second pixel, 2 cycles.
  - Outputs are registered. data_valid is 0 in every non-emitting cycle; data fields hold their last value.
- Overflow: none is possible. A group needs at least 4 input cycles and emission takes 2. An assertion checks that pend is never set while a pair is still emitting.
- frame_done: asserted with the second pixel of a pair when px=IMG_WIDTH-2 and py=IMG_HEIGHT-1.
- SOF while locked:
  - If phase!=PH_Y0, or ix!=0, or iy!=0: pulse sync_err the next cycle. Drop the partial group.
  - In all cases (aligned or not): force ix=iy=0 and treat the byte as Y0 (phase becomes PH_U).
  - A pair already in the buffer is still emitted intact, with its original coordinates.
- in_sof with in_valid=0 has no effect.
- Reset mid-operation: the next cycle has all outputs 0, the pair in flight is lost, and locked=0, so a new SOF is required.

Decomposition:
- Package yuv_stream_pkg holds:
  - the phase enum PH_Y0/PH_U/PH_Y1/PH_V;
  - default IMG_WIDTH/IMG_HEIGHT constants, shared with the RGB converter;
  - the 10-bit coordinate width constant.
- No sub-module is required. The pair emitter, a 2-cycle sequencer, may optionally be split out as yuyv_pair_emitter.

Test Plan:
1. Reset, then bytes 11,22,33,44 with in_sof=0 -> data_valid stays 0 (not locked).
2. SOF + contiguous 10,80,20,C0 -> cycle after C0: pixel (0,0) y=10 u=80 v=C0. Next cycle: pixel (1,0) y=20 u=80 v=C0. Then data_valid=0.
3. Same group with in_valid every 3rd cycle -> identical two pixels, each appearing 1 and 2 cycles after the C0 byte.
4. Full 320x466 frame of incrementing bytes -> exactly 149120 data_valid cycles. frame_done once, at (319,465). Next frame's first pixel is (0,0) without a new SOF.
5. After SOF + Y0,U, a second SOF arrives -> sync_err pulse 1 cycle later, no output for the partial group. The next complete group emits at (0,0),(1,0).
6. rst asserted on the cycle pixel (0,0) is emitted -> next cycle data_valid=0 and the (1,0) pixel never appears. Bytes without SOF produce no output.
